aes_key_expansion: RTL and testbench

- Iterative AES-128 key schedule. It sits directly upstream of the AES decipher and cipher cores.
- It takes a 128-bit cipher key and produces all 11 round keys. The round keys are packed into the flat 1408-bit round_keys bus that those cores consume.
- It computes one round key per clock using a single g-function (4 S-box lookups plus Rcon), then holds the result stable until the next accepted start.

---
 rtl/aes_key_expansion.sv | 139 +++++++++++++
 tb/tb_aes_key_expansion.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock from a single
// g-function. All 11 round keys are packed into a flat bus, key 0 in the MSBs.
module aes_key_expansion #(
  parameter int DATA_WIDTH           = 128,
  parameter int NUM_OF_ROUNDS        = 10,
  parameter int EXPANSIONED_KEY_SIZE = (NUM_OF_ROUNDS + 1) * DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_key,
  input  logic [DATA_WIDTH-1:0]           cipher_key,
  output logic [EXPANSIONED_KEY_SIZE-1:0] round_keys,
  output logic                            key_valid,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t                          state_q, state_d;
  logic [EXPANSIONED_KEY_SIZE-1:0] round_keys_q, round_keys_d;
  logic [3:0]                      counter_q, counter_d;
  logic [7:0]                      rcon_q, rcon_d;
  logic                            key_valid_q, key_valid_d;
  logic                            busy_q, busy_d;

  logic [DATA_WIDTH-1:0] prev_key;
  logic [DATA_WIDTH-1:0] next_key;
  logic [31:0]           rot_w3, sub_w3, w0, w1, w2, w3;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Forward S-box computed as a^254 (multiplicative inverse, 0 maps to 0)
  // followed by the affine transform; purely combinational.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Next-state logic: g-function on the previous slot plus the FSM.
  always_comb begin
    state_d      = state_q;
    round_keys_d = round_keys_q;
    counter_d    = counter_q;
    rcon_d       = rcon_q;
    key_valid_d  = key_valid_q;
    busy_d       = busy_q;

    prev_key = '0;
    for (int k = 1; k <= NUM_OF_ROUNDS; k++) begin
      if (int'(counter_q) == k)
        prev_key = round_keys_q[EXPANSIONED_KEY_SIZE-1-(k-1)*DATA_WIDTH -: DATA_WIDTH];
    end

    rot_w3   = {prev_key[23:0], prev_key[31:24]};
    sub_w3   = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
    w0       = prev_key[127:96] ^ sub_w3 ^ {rcon_q, 24'h000000};
    w1       = prev_key[95:64] ^ w0;
    w2       = prev_key[63:32] ^ w1;
    w3       = prev_key[31:0]  ^ w2;
    next_key = {w0, w1, w2, w3};

    case (state_q)
      IDLE, DONE: begin
        // A restart from DONE leaves older slots in place; key_valid guards them.
        if (start_key) begin
          round_keys_d[EXPANSIONED_KEY_SIZE-1 -: DATA_WIDTH] = cipher_key;
          counter_d   = 4'd1;
          rcon_d      = 8'h01;
          key_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        for (int k = 1; k <= NUM_OF_ROUNDS; k++) begin
          if (int'(counter_q) == k)
            round_keys_d[EXPANSIONED_KEY_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH] = next_key;
        end
        counter_d = counter_q + 4'd1;
        rcon_d    = xtime(rcon_q);
        if (int'(counter_q) == NUM_OF_ROUNDS) begin
          state_d     = DONE;
          key_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears the schedule and aborts any expansion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      round_keys_q <= '0;
      counter_q    <= 4'd0;
      rcon_q       <= 8'h01;
      key_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_keys_q <= round_keys_d;
      counter_q    <= counter_d;
      rcon_q       <= rcon_d;
      key_valid_q  <= key_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign round_keys = round_keys_q;
  assign key_valid  = key_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: known-answer vectors, a word-level
// reference key schedule, and multi-cycle corner sequences.
module tb_aes_key_expansion;

  logic          clk;
  logic          rst;
  logic          start_key;
  logic [127:0]  cipher_key;
  logic [1407:0] round_keys;
  logic          key_valid;
  logic          busy;

  int n_cmp;
  int n_err;

  logic [7:0] exp_t [256];
  logic [7:0] log_t [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] s1;
    logic [127:0] s10;
  } vec_t;
  vec_t vecs [2];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expansion dut (
    .clk        (clk),
    .rst        (rst),
    .start_key  (start_key),
    .cipher_key (cipher_key),
    .round_keys (round_keys),
    .key_valid  (key_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] slot(input logic [1407:0] rk, input int s);
    return rk[1407-128*s -: 128];
  endfunction

  // Exp/log tables of the AES field with generator 3.
  task automatic build_tables();
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = 8'(i);
      x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
    end
  endtask

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c   = 8'h63;
    inv = (a == 8'h00) ? 8'h00 : exp_t[(255 - int'(log_t[a])) % 255];
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  // Textbook word-array key expansion, w[0..43].
  function automatic logic [1407:0] model_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [7:0]    rc [10];
    logic [31:0]   t;
    logic [1407:0] r;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int j = 0; j < 4; j++) w[j] = key[127-32*j -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t = t ^ {rc[i/4-1], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  // Start an expansion, optionally pulse a second start at cycle inj, then
  // check busy/key_valid timing and the full schedule against the model.
  task automatic run_seq(input logic [127:0] key, input int inj,
                         input logic [127:0] inj_key, input string name);
    int            busy_cnt;
    int            first_v;
    logic [1407:0] exp;
    exp      = model_expand(key);
    busy_cnt = 0;
    first_v  = -1;
    @(negedge clk);
    start_key  = 1'b1;
    cipher_key = key;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (key_valid && first_v < 0) first_v = c;
      start_key = (c == inj);
      if (c == inj) cipher_key = inj_key;
      else          cipher_key = {$urandom, $urandom, $urandom, $urandom};
    end
    start_key = 1'b0;
    chk({name, "_busy_cycles"}, 128'(busy_cnt), 128'd10);
    chk({name, "_valid_latency"}, 128'(first_v), 128'd10);
    chk({name, "_valid_now"}, 128'(key_valid), 128'd1);
    for (int s = 0; s <= 10; s++)
      chk($sformatf("%s_slot%0d", name, s), slot(round_keys, s), slot(exp, s));
  endtask

  initial begin
    logic [1407:0] snap;
    logic          chg;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    start_key  = 1'b0;
    cipher_key = '0;
    build_tables();

    vecs[0] = '{FIPS_KEY,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_keys_nonzero", 128'(|round_keys), 128'd0);
    chk("reset_key_valid", 128'(key_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    rst = 1'b0;

    // Known-answer vectors
    for (int i = 0; i < 2; i++) begin
      run_seq(vecs[i].key, -1, '0, $sformatf("kat%0d", i));
      chk($sformatf("kat%0d_slot0_const", i), slot(round_keys, 0), vecs[i].key);
      chk($sformatf("kat%0d_slot1_const", i), slot(round_keys, 1), vecs[i].s1);
      chk($sformatf("kat%0d_slot10_const", i), slot(round_keys, 10), vecs[i].s10);
    end

    // Start while busy is ignored
    run_seq(FIPS_KEY, 2, '0, "busy_restart");
    chk("busy_restart_slot10_const", slot(round_keys, 10), vecs[0].s10);

    // Restart from DONE with the zero key
    run_seq(128'h0, -1, '0, "done_restart");
    chk("done_restart_slot10_const", slot(round_keys, 10), vecs[1].s10);

    // Idle hold with toggling cipher_key
    snap = round_keys;
    chg  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cipher_key = {$urandom, $urandom, $urandom, $urandom};
      if (round_keys !== snap || key_valid !== 1'b1) chg = 1'b1;
    end
    chk("idle_hold_changed", 128'(chg), 128'd0);

    // Reset in the middle of an expansion
    @(negedge clk);
    start_key  = 1'b1;
    cipher_key = FIPS_KEY;
    @(negedge clk);
    start_key = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before_rst", 128'(busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_keys_nonzero", 128'(|round_keys), 128'd0);
    chk("mid_rst_key_valid", 128'(key_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_stays_idle", 128'(busy), 128'd0);
    run_seq(FIPS_KEY, -1, '0, "after_rst");

    // rst and start_key on the same edge: rst wins
    @(negedge clk);
    rst        = 1'b1;
    start_key  = 1'b1;
    cipher_key = 128'h0;
    @(negedge clk);
    rst       = 1'b0;
    start_key = 1'b0;
    @(negedge clk);
    chk("rst_wins_busy", 128'(busy), 128'd0);
    chk("rst_wins_keys_nonzero", 128'(|round_keys), 128'd0);

    // Random keys against the reference model
    for (int i = 0; i < 8; i++)
      run_seq({$urandom, $urandom, $urandom, $urandom}, -1, '0, $sformatf("rand%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
